core_reg_writeback: RTL and testbench
=====================================

// Module: core_reg_writeback
// PURPOSE
//  Write side of the core register file: merges ALU results (single-cycle, cannot stall) and load results
//  (valid/ready, buffered) into one registered write port per cycle driving the file's wr_* inputs.
//  Tracks in-flight loads for decode hazard checks; throttles the ALU when buffered loads starve.
// PARAMETERS
//  LOAD_DEPTH  4   load FIFO entries (power of two, >=2)
//  STARVE_MAX  8   cycles a full-FIFO head may wait before alu_stall asserts (1..255)
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           reset, asynchronous, active-low
//  flush          in   1           drop all buffered loads (exception/abort)
//  alu_valid      in   1           ALU result present this cycle
//  alu_r          in   reg_num     ALU destination
//  alu_value      in   word        ALU result
//  alu_file       in   1           1: commit to file; 0: forward-only (wr_enable_file low)
//  alu_stall      out  1           upstream must hold alu_valid low next cycle
//  mem_valid      in   1           load result offered
//  mem_ready      out  1           load result accepted when valid&ready
//  mem_r          in   reg_num     load destination
//  mem_value      in   word        load data
//  hz_r           in   reg_num     decode query register
//  hz_busy        out  1           a buffered load targets hz_r
//  wr_enable      out  1           write in flight (file forwarding compare)
//  wr_enable_file out  1           commit to file array
//  wr_r           out  reg_num     write destination
//  wr_value       out  word        value written to file
//  wr_current     out  word        value forwarded to reads (== wr_value)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty (mem_ready=1 after reset), age counter 0, alu_stall 0.
//  - Output regs updated every edge; one write per cycle; ALU latency 1 (alu_valid@N -> wr_enable@N+1).
//  - Select at edge: alu_valid -> ALU (wr_enable_file=alu_file); else FIFO non-empty -> pop head
//    (wr_enable_file=1); else wr_enable=wr_enable_file=0, wr_r/wr_value hold.
//  - mem_ready = !full (registered state only, no comb path from mem_valid). Push on valid&ready.
//  - Simultaneous push+pop on full FIFO not allowed (ready is low); push+pop otherwise both happen, count unchanged.
//  - Load latency without bypass: accept@N -> earliest wr_enable@N+2. FIFO order preserved; loads to same
//    register commit oldest first. ALU write to a register with a buffered load: both commit in issue order
//    (ALU first if it wins the cycle); WAW ordering is upstream's job via hz_busy.
//  - hz_busy = OR over valid entries of (entry.r == hz_r); combinational from FIFO state; popped-this-cycle
//    entry still counts until the edge.
//  - Age counter: counts cycles with FIFO full and no pop; clears on pop or flush; saturates at STARVE_MAX.
//    alu_stall registered: 1 when age reaches STARVE_MAX-1 and no pop; cleared cycle after a pop.
//    alu_valid while alu_stall=1 is a protocol error (assertion), ALU still wins.
//  - flush: FIFO emptied at that edge, incoming push that cycle dropped, mem_ready forced 0 during flush,
//    age cleared; an ALU write in the same cycle is still issued; load head not issued.
//  - Pointer wrap: log2(LOAD_DEPTH)+1-bit pointers, full = MSB differ & rest equal.
//  - rst_n assertion mid-operation: immediate clear of all state and outputs; buffered loads lost.
// CONFIGURATION
//  CORE_REG_WB_BYPASS_EN defined: if FIFO empty, no ALU valid and no flush, an accepted load goes straight
//  to output regs (accept@N -> wr_enable@N+1), not written into FIFO, hz_busy not raised for it.
//  Undefined: every load passes through the FIFO (2-cycle minimum latency).
// STRUCTURE
//  - Shared package core/uarch.sv: word, reg_num, NUM_GPREGS; add typedef wb_entry {reg_num r; word value;}.
//  - Sub-module core_reg_wb_fifo: LOAD_DEPTH-entry FIFO of wb_entry, push/pop/flush, full/empty, and
//    exported valid vector + entries for hz compare.
// TESTING
//  1 Reset: rst_n=0 -> wr_enable=0, wr_enable_file=0, mem_ready=1, alu_stall=0, hz_busy=0.
//  2 ALU alu_r=3, value 0xDEADBEEF, alu_file=1 @N -> wr_enable=1, wr_r=3, wr_value=0xDEADBEEF @N+1; alu_file=0 -> wr_enable_file=0.
//  3 Loads r5=0x11,r5=0x22,r6=0x33 back-to-back, no ALU -> writes in order 0x11,0x22,0x33; hz_r=5 busy until 0x22 issues.
//  4 Fill FIFO (4 loads) with continuous ALU -> mem_ready=0; alu_stall after STARVE_MAX=8 cycles; drop ALU -> head pops, stall clears.
//  5 flush with 3 buffered loads + alu_valid same cycle -> ALU write issued, no load writes follow, hz_busy=0, mem_ready=1 next.
//  6 Single load to empty FIFO, idle ALU -> wr_enable @N+2; with CORE_REG_WB_BYPASS_EN @N+1.

Source files
------------

// File: rtl/core_reg_writeback_pkg.sv
// Shared types for the register-file write side: word/register widths, the
// buffered load entry and the write-source select used by core_reg_writeback.
package core_reg_writeback_pkg;

  localparam int NUM_GPREGS = 32;
  localparam int WORD_W     = 32;

  typedef logic [WORD_W-1:0]             word;
  typedef logic [$clog2(NUM_GPREGS)-1:0] reg_num;

  typedef struct packed {
    reg_num r;
    word    value;
  } wb_entry;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LOAD,
    SRC_BYPASS
  } wb_src_e;

endpackage

// File: rtl/core_reg_writeback_if.sv
// ALU, load, hazard-query and file write-port signals of the writeback block.
// slave = writeback block, master = surrounding core / environment.
interface core_reg_writeback_if;
  import core_reg_writeback_pkg::*;

  logic   alu_valid;
  reg_num alu_r;
  word    alu_value;
  logic   alu_file;
  logic   alu_stall;

  logic   mem_valid;
  logic   mem_ready;
  reg_num mem_r;
  word    mem_value;

  reg_num hz_r;
  logic   hz_busy;

  logic   wr_enable;
  logic   wr_enable_file;
  reg_num wr_r;
  word    wr_value;
  word    wr_current;

  modport slave (
    input  alu_valid, alu_r, alu_value, alu_file, mem_valid, mem_r, mem_value, hz_r,
    output alu_stall, mem_ready, hz_busy, wr_enable, wr_enable_file, wr_r, wr_value, wr_current
  );

  modport master (
    output alu_valid, alu_r, alu_value, alu_file, mem_valid, mem_r, mem_value, hz_r,
    input  alu_stall, mem_ready, hz_busy, wr_enable, wr_enable_file, wr_r, wr_value, wr_current
  );

endinterface

// File: rtl/core_reg_wb_fifo.sv
// Load result FIFO with wrap-bit pointers; exports per-slot valid bits and the
// raw storage so the parent can run the decode hazard compare.
module core_reg_wb_fifo
  import core_reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  wb_entry          data_i,
  output wb_entry          head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [DEPTH-1:0] valid_o,
  output wb_entry          entries_o [DEPTH]
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic        push_ok, pop_ok;
  wb_entry     mem_q [DEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which slots hold meaningful data.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    localparam logic [AW-1:0] IDX = AW'(i);
    logic [AW-1:0] offset;
    assign offset     = IDX - rd_ptr_q[AW-1:0];
    assign valid_o[i] = ({1'b0, offset} < count);
  end

  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign entries_o = mem_q;

endmodule

// File: rtl/core_reg_writeback.sv
// Register-file write port: ALU results win each cycle, buffered loads fill idle slots.
// Define CORE_REG_WB_BYPASS_EN to let a load into an idle, empty block skip the FIFO.
module core_reg_writeback
  import core_reg_writeback_pkg::*;
#(
  parameter int LOAD_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  core_reg_writeback_if.slave  wb
);

  localparam logic [7:0] AGE_MAX = 8'(STARVE_MAX);
  localparam logic [7:0] AGE_ARM = 8'(STARVE_MAX - 1);

  wb_entry                head, entries [LOAD_DEPTH];
  logic [LOAD_DEPTH-1:0]  valid;
  logic                   full, empty, mem_ready, push_acc, bypass, pop, hz_busy;
  wb_src_e                src;

  logic       en_q, en_d, file_q, file_d, stall_q, stall_d;
  reg_num     r_q, r_d;
  word        value_q, value_d;
  logic [7:0] age_q, age_d;

  // Ready depends on registered fullness and flush only, never on mem_valid.
  assign mem_ready = !full && !flush_i;
  assign push_acc  = wb.mem_valid && mem_ready;
  assign pop       = !wb.alu_valid && !empty && !flush_i;

`ifdef CORE_REG_WB_BYPASS_EN
  assign bypass = push_acc && empty && !wb.alu_valid;
`else
  assign bypass = 1'b0;
`endif

  core_reg_wb_fifo #(.DEPTH(LOAD_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_acc && !bypass),
    .pop_i     (pop),
    .flush_i   (flush_i),
    .data_i    ('{r: wb.mem_r, value: wb.mem_value}),
    .head_o    (head),
    .full_o    (full),
    .empty_o   (empty),
    .valid_o   (valid),
    .entries_o (entries)
  );

  always_comb begin
    src = SRC_NONE;
    if (wb.alu_valid)  src = SRC_ALU;
    else if (pop)      src = SRC_LOAD;
    else if (bypass)   src = SRC_BYPASS;
  end

  always_comb begin
    en_d    = 1'b1;
    file_d  = 1'b1;
    r_d     = r_q;
    value_d = value_q;
    unique case (src)
      SRC_ALU:    begin file_d = wb.alu_file; r_d = wb.alu_r; value_d = wb.alu_value; end
      SRC_LOAD:   begin r_d = head.r;   value_d = head.value;   end
      SRC_BYPASS: begin r_d = wb.mem_r; value_d = wb.mem_value; end
      default:    begin en_d = 1'b0; file_d = 1'b0; end
    endcase
  end

  // Starvation: a full FIFO whose head keeps losing to the ALU eventually throttles it.
  always_comb begin
    age_d = age_q;
    if (flush_i || pop || !full) age_d = '0;
    else if (age_q < AGE_MAX)    age_d = age_q + 8'd1;
    stall_d = full && !pop && !flush_i && (age_q >= AGE_ARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      file_q  <= 1'b0;
      r_q     <= '0;
      value_q <= '0;
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      en_q    <= en_d;
      file_q  <= file_d;
      r_q     <= r_d;
      value_q <= value_d;
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    hz_busy = 1'b0;
    for (int i = 0; i < LOAD_DEPTH; i++) begin
      if (valid[i] && (entries[i].r == wb.hz_r)) hz_busy = 1'b1;
    end
  end

  assign wb.mem_ready      = mem_ready;
  assign wb.alu_stall      = stall_q;
  assign wb.hz_busy        = hz_busy;
  assign wb.wr_enable      = en_q;
  assign wb.wr_enable_file = file_q;
  assign wb.wr_r           = r_q;
  assign wb.wr_value       = value_q;
  assign wb.wr_current     = value_q;

  a_no_alu_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb.alu_valid && wb.alu_stall));

endmodule

// File: tb/tb_core_reg_writeback.sv
// Directed bench for core_reg_writeback: a queue-based model of the write side is
// compared every cycle, with literal expectations pinning the key scenarios.
module tb_core_reg_writeback;
  import core_reg_writeback_pkg::*;

  localparam int D  = 4;
  localparam int SM = 8;
`ifdef CORE_REG_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   tests = 0;
  int   failed = 0;

  core_reg_writeback_if wb ();

  core_reg_writeback #(.LOAD_DEPTH(D), .STARVE_MAX(SM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .wb      (wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: a plain queue of pending loads plus the last issued write.
  wb_entry    mq[$];
  wb_entry    e;
  logic       m_en, m_file;
  logic [4:0] m_r;
  word        m_v;
  int         m_wait;
  logic       m_stall, m_full, m_acc, m_pop;
  word        wr_log[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_en = 0; m_file = 0; m_r = 0; m_v = 0; m_wait = 0; m_stall = 0;
    end else begin
      m_full = (mq.size() == D);
      m_acc  = wb.mem_valid && !m_full && !flush;
      m_pop  = 0;
      if (wb.alu_valid) begin
        m_en = 1; m_file = wb.alu_file; m_r = wb.alu_r; m_v = wb.alu_value;
      end else if (!flush && mq.size() > 0) begin
        e = mq.pop_front();
        m_en = 1; m_file = 1; m_r = e.r; m_v = e.value; m_pop = 1;
      end else if (BYPASS && m_acc && mq.size() == 0) begin
        m_en = 1; m_file = 1; m_r = wb.mem_r; m_v = wb.mem_value; m_acc = 0;
      end else begin
        m_en = 0; m_file = 0;
      end
      if (flush)      mq.delete();
      else if (m_acc) mq.push_back('{r: wb.mem_r, value: wb.mem_value});
      if (flush || m_pop || !m_full) m_wait = 0;
      else if (m_wait < SM)          m_wait++;
      m_stall = (m_wait == SM);
    end
  end

  always @(negedge clk) begin
    logic exp_hz;
    exp_hz = 0;
    foreach (mq[i]) if (mq[i].r == wb.hz_r) exp_hz = 1;
    check("cyc_wr_enable",      wb.wr_enable,      m_en);
    check("cyc_wr_enable_file", wb.wr_enable_file, m_file);
    check("cyc_wr_r",           wb.wr_r,           m_r);
    check("cyc_wr_value",       wb.wr_value,       m_v);
    check("cyc_wr_current",     wb.wr_current,     m_v);
    check("cyc_alu_stall",      wb.alu_stall,      m_stall);
    check("cyc_mem_ready",      wb.mem_ready,      (mq.size() < D) && !flush);
    check("cyc_hz_busy",        wb.hz_busy,        exp_hz);
    if (rst_n && wb.wr_enable) wr_log.push_back(wb.wr_value);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 0; flush = 0;
    wb.alu_valid = 0; wb.alu_r = 0; wb.alu_value = 0; wb.alu_file = 0;
    wb.mem_valid = 0; wb.mem_r = 0; wb.mem_value = 0; wb.hz_r = 0;

    // 1: reset state
    repeat (2) cyc();
    check("rst_wr_enable", wb.wr_enable, 0);
    check("rst_wr_file",   wb.wr_enable_file, 0);
    check("rst_mem_ready", wb.mem_ready, 1);
    check("rst_alu_stall", wb.alu_stall, 0);
    check("rst_hz_busy",   wb.hz_busy, 0);
    rst_n = 1;
    cyc();

    // 2: ALU writes, file commit and forward-only
    wb.alu_valid = 1; wb.alu_r = 3; wb.alu_value = 32'hDEADBEEF; wb.alu_file = 1;
    cyc();
    check("alu_en",    wb.wr_enable, 1);
    check("alu_r",     wb.wr_r, 3);
    check("alu_value", wb.wr_value, 32'hDEADBEEF);
    check("alu_file",  wb.wr_enable_file, 1);
    wb.alu_r = 7; wb.alu_value = 32'h1234; wb.alu_file = 0;
    cyc();
    check("alu_fwd_en",   wb.wr_enable, 1);
    check("alu_fwd_file", wb.wr_enable_file, 0);
    wb.alu_valid = 0;
    cyc();
    check("idle_en",   wb.wr_enable, 0);
    check("idle_hold", wb.wr_value, 32'h1234);

    // 3: back-to-back loads, order and hazard tracking
    wr_log.delete();
    wb.hz_r = 5;
    wb.mem_valid = 1; wb.mem_r = 5; wb.mem_value = 32'h11;
    cyc();
    check("ld_hz_a", wb.hz_busy, BYPASS ? 0 : 1);
    wb.mem_r = 5; wb.mem_value = 32'h22;
    cyc();
    check("ld_hz_b", wb.hz_busy, BYPASS ? 0 : 1);
    wb.mem_r = 6; wb.mem_value = 32'h33;
    cyc();
    check("ld_hz_c", wb.hz_busy, 0);
    wb.mem_valid = 0;
    repeat (2) cyc();
    check("ld_count", wr_log.size(), 3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++)
      check("ld_order", wr_log[i], 32'h11 * (i + 1));

    // 4: fill under continuous ALU, starvation stall, release
    wb.alu_valid = 1; wb.alu_file = 1; wb.alu_r = 1;
    for (int i = 0; i < 4; i++) begin
      wb.mem_valid = 1; wb.mem_r = 5'(10 + i); wb.mem_value = 32'h100 + 32'(i);
      wb.alu_value = 32'hA000 + 32'(i);
      cyc();
    end
    wb.mem_valid = 0;
    check("fill_ready", wb.mem_ready, 0);
    n = 0;
    while (!wb.alu_stall && n < 20) begin
      cyc();
      n++;
    end
    wb.alu_valid = 0;
    check("stall_delay", n, SM);
    cyc();
    check("stall_clear",  wb.alu_stall, 0);
    check("stall_pop_r",  wb.wr_r, 10);
    check("stall_pop_v",  wb.wr_value, 32'h100);
    check("stall_ready",  wb.mem_ready, 1);
    repeat (3) cyc();
    check("drain_last", wb.wr_value, 32'h103);

    // 5: flush with buffered loads and a same-cycle ALU write
    wb.alu_valid = 1; wb.alu_r = 2;
    for (int i = 0; i < 3; i++) begin
      wb.mem_valid = 1; wb.mem_r = 5'(20 + i); wb.mem_value = 32'h200 + 32'(i);
      cyc();
    end
    wb.hz_r = 21; flush = 1;
    wb.alu_r = 9; wb.alu_value = 32'hF1F1; wb.mem_r = 23; wb.mem_value = 32'h999;
    #1;
    check("flush_ready_low", wb.mem_ready, 0);
    check("flush_hz_before", wb.hz_busy, 1);
    cyc();
    flush = 0; wb.alu_valid = 0; wb.mem_valid = 0;
    #1;
    check("flush_alu_en", wb.wr_enable, 1);
    check("flush_alu_r",  wb.wr_r, 9);
    check("flush_alu_v",  wb.wr_value, 32'hF1F1);
    check("flush_hz",     wb.hz_busy, 0);
    check("flush_ready",  wb.mem_ready, 1);
    cyc();
    check("flush_no_ld_a", wb.wr_enable, 0);
    cyc();
    check("flush_no_ld_b", wb.wr_enable, 0);

    // 6: single load latency
    wb.mem_valid = 1; wb.mem_r = 4; wb.mem_value = 32'h44;
    cyc();
    wb.mem_valid = 0;
    check("lat_n1", wb.wr_enable, BYPASS ? 1 : 0);
    cyc();
    check("lat_n2", wb.wr_enable, BYPASS ? 0 : 1);
    check("lat_v",  wb.wr_value, 32'h44);

    // 7: reset mid-operation drops buffered loads
    wb.alu_valid = 1; wb.alu_r = 8; wb.alu_value = 32'h77; wb.hz_r = 30;
    for (int i = 0; i < 2; i++) begin
      wb.mem_valid = 1; wb.mem_r = 30; wb.mem_value = 32'h300 + 32'(i);
      cyc();
    end
    wb.alu_valid = 0; wb.mem_valid = 0;
    #1;
    check("mid_hz_before", wb.hz_busy, 1);
    rst_n = 0;
    #1;
    check("mid_rst_en",    wb.wr_enable, 0);
    check("mid_rst_value", wb.wr_value, 0);
    check("mid_rst_ready", wb.mem_ready, 1);
    check("mid_rst_hz",    wb.hz_busy, 0);
    cyc();
    rst_n = 1;
    repeat (2) cyc();
    check("mid_rst_lost", wb.wr_enable, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
